qspi_line_reader: RTL and testbench

- Parametrised next-generation Quad I/O (0xEB) flash line fetcher for the XIP controller; refills the direct-mapped cache.
- Adds programmable line size, SCK divider, dummy-cycle count and continuous-read (command-skip) mode.
- Adds explicit busy and chip-select-high gap control.
- Sits between the cache refill logic and the QSPI pads.

---
 rtl/qspi_line_reader_if.sv | 36 +++
 rtl/qspi_line_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_qspi_line_reader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_line_reader_if.sv
// ============================================================================
// Module      : qspi_line_reader_if
// Description : Cache-refill request/response and QSPI pad bundle for the
//               Quad I/O line fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qspi_line_reader_if #(
  parameter int ADDR_W     = 24,
  parameter int LINE_BYTES = 16
);
  logic [ADDR_W-1:0]       addr;
  logic                    rd;
  logic                    cont_en;
  logic                    busy;
  logic                    done;
  logic [8*LINE_BYTES-1:0] line;
  logic                    sck;
  logic                    ce_n;
  logic [3:0]              din;
  logic [3:0]              dout;
  logic                    douten;

  modport slave (
    input  addr, rd, cont_en, din,
    output busy, done, line, sck, ce_n, dout, douten
  );

  modport master (
    output addr, rd, cont_en, din,
    input  busy, done, line, sck, ce_n, dout, douten
  );
endinterface

`default_nettype wire

// File: rtl/qspi_line_reader.sv
// ============================================================================
// Module      : qspi_line_reader
// Description : Quad I/O (0xEB) flash line fetcher with continuous-read mode,
//               programmable SCK divider, dummy count and CE gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_line_reader #(
  parameter int         LINE_BYTES   = 16,
  parameter int         ADDR_W       = 24,
  parameter int         CLK_DIV      = 1,
  parameter int         DUMMY_CYCLES = 4,
  parameter int         CE_GAP       = 2,
  parameter logic [7:0] MODE_CONT    = 8'hA0
) (
  input  logic               clk,
  input  logic               rst,
  qspi_line_reader_if.slave  bus
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_CNT_W = 16;
  localparam int c_NI_W  = $clog2(2*LINE_BYTES);
  localparam int c_AB_W  = $clog2(ADDR_W);

  localparam logic [7:0]         c_CMD        = 8'hEB;
  localparam logic [ADDR_W-1:0]  c_LO_MASK    = ADDR_W'(LINE_BYTES-1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV-1);
  localparam logic [c_CNT_W-1:0] c_CMD_LAST   = c_CNT_W'(7);
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST  = c_CNT_W'(ADDR_W/4-1);
  localparam logic [c_CNT_W-1:0] c_MODE_LAST  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_DUMMY_LAST = c_CNT_W'(DUMMY_CYCLES-1);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST  = c_CNT_W'(2*LINE_BYTES-1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(CE_GAP-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_MODE  = 3'd3,
    S_DUMMY = 3'd4,
    S_DATA  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_DIV_W-1:0]   div_q, div_d;
  logic                 sck_q, sck_d;
  logic                 ce_n_q, ce_n_d;
  logic                 done_q, done_d;
  logic                 douten_q, douten_d;
  logic [3:0]           dout_q, dout_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 cont_q, cont_d;
  logic                 cont_active_q, cont_active_d;
  logic [8*LINE_BYTES-1:0] line_q;

  logic                 w_tick;
  logic                 w_fall;
  logic                 w_cap;
  logic [c_NI_W-1:0]    w_lidx;
  logic [c_AB_W-1:0]    w_abase;
  logic [7:0]           w_mode;

  assign w_tick = (div_q == c_DIV_LAST);
  // An SPI cycle ends on the clk edge that drives sck high->low.
  assign w_fall = (state_q inside {S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA}) && sck_q && w_tick;
  // Even nibble index lands in the high half of its byte.
  assign w_lidx = c_NI_W'(cnt_q) ^ c_NI_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    sck_d         = sck_q;
    ce_n_d        = ce_n_q;
    done_d        = 1'b0;
    addr_d        = addr_q;
    cont_d        = cont_q;
    cont_active_d = cont_active_q;
    w_cap         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rd) begin
          addr_d  = bus.addr & ~c_LO_MASK;
          cont_d  = bus.cont_en;
          ce_n_d  = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          cnt_d   = '0;
          state_d = cont_active_q ? S_ADDR : S_CMD;
        end
      end

      S_GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end

      default: begin
        if (w_tick) begin
          div_d = '0;
          sck_d = ~sck_q;
        end else begin
          div_d = div_q + c_DIV_W'(1);
        end

        if (w_fall) begin
          cnt_d = cnt_q + c_CNT_W'(1);
          case (state_q)
            S_CMD: if (cnt_q == c_CMD_LAST) begin
              state_d = S_ADDR;
              cnt_d   = '0;
            end
            S_ADDR: if (cnt_q == c_ADDR_LAST) begin
              state_d = S_MODE;
              cnt_d   = '0;
            end
            S_MODE: if (cnt_q == c_MODE_LAST) begin
              state_d = (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
              cnt_d   = '0;
            end
            S_DUMMY: if (cnt_q == c_DUMMY_LAST) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end
            S_DATA: begin
              w_cap = 1'b1;
              if (cnt_q == c_DATA_LAST) begin
                state_d       = S_GAP;
                cnt_d         = '0;
                div_d         = '0;
                sck_d         = 1'b0;
                ce_n_d        = 1'b1;
                done_d        = 1'b1;
                cont_active_d = cont_q;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    // Pad outputs are derived from the next state so they switch together
    // with ce_n fall or the sck falling edge and stay stable while sck is high.
    w_mode   = cont_d ? MODE_CONT : 8'h00;
    w_abase  = c_AB_W'(ADDR_W-4) - c_AB_W'({cnt_d, 2'b00});
    dout_d   = 4'h0;
    douten_d = 1'b0;
    case (state_d)
      S_CMD: begin
        douten_d = 1'b1;
        dout_d   = {3'b000, c_CMD[3'(~cnt_d[2:0])]};
      end
      S_ADDR: begin
        douten_d = 1'b1;
        dout_d   = addr_d[w_abase +: 4];
      end
      S_MODE: begin
        douten_d = 1'b1;
        dout_d   = cnt_d[0] ? w_mode[3:0] : w_mode[7:4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      sck_q         <= 1'b0;
      ce_n_q        <= 1'b1;
      done_q        <= 1'b0;
      douten_q      <= 1'b0;
      dout_q        <= 4'h0;
      addr_q        <= '0;
      cont_q        <= 1'b0;
      cont_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      sck_q         <= sck_d;
      ce_n_q        <= ce_n_d;
      done_q        <= done_d;
      douten_q      <= douten_d;
      dout_q        <= dout_d;
      addr_q        <= addr_d;
      cont_q        <= cont_d;
      cont_active_q <= cont_active_d;
    end
  end

  // Line storage carries no reset; its contents are undefined until filled.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      line_q[{w_lidx, 2'b00} +: 4] <= bus.din;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.line   = line_q;
  assign bus.sck    = sck_q;
  assign bus.ce_n   = ce_n_q;
  assign bus.dout   = dout_q;
  assign bus.douten = douten_q;

endmodule

`default_nettype wire

// File: tb/tb_qspi_line_reader.sv
// ============================================================================
// Module      : tb_qspi_line_reader
// Description : Scoreboard bench for qspi_line_reader with a behavioural
//               Quad I/O flash model, two parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_line_reader;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  qspi_line_reader_if #(.ADDR_W(24), .LINE_BYTES(16)) if0 ();
  qspi_line_reader_if #(.ADDR_W(24), .LINE_BYTES(32)) if1 ();

  qspi_line_reader #(
    .LINE_BYTES(16), .ADDR_W(24), .CLK_DIV(1), .DUMMY_CYCLES(4), .CE_GAP(2), .MODE_CONT(8'hA0)
  ) u_dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));

  qspi_line_reader #(
    .LINE_BYTES(32), .ADDR_W(24), .CLK_DIV(3), .DUMMY_CYCLES(6), .CE_GAP(2), .MODE_CONT(8'hA0)
  ) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  typedef struct {
    logic [255:0] line;
    logic [127:0] drv;
    int           lat;
    int           acc;
    int           ndrv;
    int           nund;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  bit           exp_cont [2];
  int           f_pre    [2];
  int           f_cyc    [2];
  int           f_ndrv   [2];
  int           f_nund   [2];
  int           f_dz     [2];
  logic [7:0]   f_seed   [2];
  logic [127:0] f_drv    [2];

  always @(posedge clk) ecnt++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input int lb, input logic [7:0] seed);
    logic [255:0] l = '0;
    for (int k = 0; k < lb; k++) l[8*k +: 8] = seed + 8'(k);
    return l;
  endfunction

  function automatic logic [127:0] mk_drv(input bit cmd, input logic [23:0] a, input logic [7:0] m);
    logic [127:0] v = '0;
    logic [7:0]   c = 8'hEB;
    if (cmd) for (int i = 7; i >= 0; i--) v = {v[123:0], 3'b000, c[i]};
    for (int n = 5; n >= 0; n--) v = {v[123:0], a[4*n +: 4]};
    v = {v[123:0], m[7:4]};
    v = {v[123:0], m[3:0]};
    return v;
  endfunction

  // Flash returns seed+k for the k-th byte of the burst.
  function automatic logic [3:0] flash_nib(input int d, input int cyc);
    int         j;
    logic [7:0] b;
    j = cyc - f_pre[d];
    if (j < 0) return 4'h0;
    b = f_seed[d] + 8'(j / 2);
    return (j % 2) ? b[3:0] : b[7:4];
  endfunction

  function automatic bit busy_of(input int d);
    return (d != 0) ? if1.busy : if0.busy;
  endfunction

  always @(negedge if0.ce_n) begin
    f_cyc[0] = 0; f_ndrv[0] = 0; f_nund[0] = 0; f_dz[0] = 0; f_drv[0] = '0;
    if0.din = flash_nib(0, 0);
  end
  always @(posedge if0.sck) if (if0.ce_n === 1'b0) begin
    if (if0.douten) begin f_drv[0] = {f_drv[0][123:0], if0.dout}; f_ndrv[0]++; end
    else begin f_nund[0]++; if (if0.dout != 4'h0) f_dz[0]++; end
  end
  always @(negedge if0.sck) if (if0.ce_n === 1'b0) begin
    f_cyc[0]++;
    if0.din = flash_nib(0, f_cyc[0]);
  end

  always @(negedge if1.ce_n) begin
    f_cyc[1] = 0; f_ndrv[1] = 0; f_nund[1] = 0; f_dz[1] = 0; f_drv[1] = '0;
    if1.din = flash_nib(1, 0);
  end
  always @(posedge if1.sck) if (if1.ce_n === 1'b0) begin
    if (if1.douten) begin f_drv[1] = {f_drv[1][123:0], if1.dout}; f_ndrv[1]++; end
    else begin f_nund[1]++; if (if1.dout != 4'h0) f_dz[1]++; end
  end
  always @(negedge if1.sck) if (if1.ce_n === 1'b0) begin
    f_cyc[1]++;
    if1.din = flash_nib(1, f_cyc[1]);
  end

  task automatic on_done(input int d);
    exp_t         e;
    logic [255:0] ln;
    logic [2:0]   st;
    int           sz;
    sz = (d != 0) ? sb1.size() : sb0.size();
    if (sz == 0) begin
      check($sformatf("d%0d_unexpected_done", d), 256'(sz), 256'(1));
      return;
    end
    if (d != 0) begin
      e = sb1.pop_front(); ln = 256'(if1.line); st = {if1.busy, if1.ce_n, if1.sck};
    end else begin
      e = sb0.pop_front(); ln = 256'(if0.line); st = {if0.busy, if0.ce_n, if0.sck};
    end
    check($sformatf("d%0d_line", d), ln, e.line);
    check($sformatf("d%0d_latency", d), 256'(ecnt - e.acc), 256'(e.lat));
    check($sformatf("d%0d_cmd_addr_mode", d), 256'(f_drv[d]), 256'(e.drv));
    check($sformatf("d%0d_driven_cycles", d), 256'(f_ndrv[d]), 256'(e.ndrv));
    check($sformatf("d%0d_input_cycles", d), 256'(f_nund[d]), 256'(e.nund));
    check($sformatf("d%0d_dummy_dout_zero", d), 256'(f_dz[d]), 256'(0));
    check($sformatf("d%0d_done_status", d), 256'(st), 256'(3'b110));
  endtask

  always @(negedge clk) begin
    if (if0.done === 1'b1) on_done(0);
    if (if1.done === 1'b1) on_done(1);
  end

  // Called at a negedge with the DUT idle; rd is accepted at the next posedge.
  task automatic issue(input int d, input logic [23:0] a, input bit cont, input logic [7:0] seed);
    exp_t        e;
    bit          cmd;
    int          lb, dv, dm;
    logic [23:0] m;
    lb  = (d != 0) ? 32 : 16;
    dv  = (d != 0) ? 3 : 1;
    dm  = (d != 0) ? 6 : 4;
    m   = 24'(lb - 1);
    cmd = !exp_cont[d];
    e.line = mk_line(lb, seed);
    e.drv  = mk_drv(cmd, a & ~m, cont ? 8'hA0 : 8'h00);
    e.ndrv = (cmd ? 8 : 0) + 6 + 2;
    e.nund = dm + 2*lb;
    e.lat  = 2*dv*(e.ndrv + e.nund);
    e.acc  = ecnt + 1;
    f_pre[d]    = e.ndrv + dm;
    f_seed[d]   = seed;
    exp_cont[d] = cont;
    if (d != 0) begin
      if1.addr = a; if1.cont_en = cont; if1.rd = 1'b1; sb1.push_back(e);
      @(negedge clk); if1.rd = 1'b0;
    end else begin
      if0.addr = a; if0.cont_en = cont; if0.rd = 1'b1; sb0.push_back(e);
      @(negedge clk); if0.rd = 1'b0;
    end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (busy_of(d) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("d%0d_idle", d), 256'(busy_of(d)), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.rd = 1'b0; if0.addr = '0; if0.cont_en = 1'b0; if0.din = 4'h0;
    if1.rd = 1'b0; if1.addr = '0; if1.cont_en = 1'b0; if1.din = 4'h0;
    exp_cont[0] = 1'b0; exp_cont[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("d0_reset_state", 256'({if0.ce_n, if0.sck, if0.busy, if0.done, if0.douten}), 256'(5'b10000));
    check("d1_reset_state", 256'({if1.ce_n, if1.sck, if1.busy, if1.done, if1.douten}), 256'(5'b10000));
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    issue(0, 24'h012345, 1'b0, 8'h00); wait_idle(0, 400);
    check("d0_line_hold", 256'(if0.line), mk_line(16, 8'h00));
    issue(0, 24'h012345, 1'b1, 8'h10); wait_idle(0, 400);
    issue(0, 24'h000020, 1'b1, 8'h33); wait_idle(0, 400);
    issue(0, 24'h00004F, 1'b0, 8'h55); wait_idle(0, 400);
    issue(0, 24'hABCDEF, 1'b0, 8'h77); wait_idle(0, 400);

    issue(1, 24'hFEDCBA, 1'b0, 8'h01); wait_idle(1, 2000);
    issue(1, 24'h123456, 1'b1, 8'h90); wait_idle(1, 2000);

    // rd pulses throughout busy, GAP included, must be dropped.
    issue(0, 24'h100000, 1'b0, 8'hA5);
    n = 0;
    while (if0.busy && n < 400) begin
      if0.rd = ~if0.rd;
      @(negedge clk);
      n++;
    end
    if0.rd = 1'b0;
    issue(0, 24'h1000F0, 1'b0, 8'h5A); wait_idle(0, 400);

    issue(0, 24'h200000, 1'b1, 8'h21); wait_idle(0, 400);
    issue(0, 24'h300000, 1'b1, 8'h42);
    repeat (50) @(negedge clk);
    #2 rst0 = 1'b1;
    #1 check("d0_async_reset", 256'({if0.ce_n, if0.sck, if0.busy, if0.done, if0.douten}), 256'(5'b10000));
    sb0.delete();
    exp_cont[0] = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    issue(0, 24'h400000, 1'b0, 8'hC3); wait_idle(0, 400);

    repeat (5) @(negedge clk);
    check("d0_scoreboard_empty", 256'(sb0.size()), 256'(0));
    check("d1_scoreboard_empty", 256'(sb1.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
